jedro_1_operand_fetch: RTL and testbench

Issue-side initiator for the integer register file. It accepts decoded instructions through a valid/ready handshake and drives the two read ports. It tracks pending destination writes in a scoreboard and forwards same-cycle writeback data. It stalls on unresolved hazards and presents registered operands to execute. It also drives the register file write port from the writeback stream.

---
 rtl/jedro_1_operand_fetch.sv | 163 ++++++++++++++++
 tb/tb_jedro_1_operand_fetch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_operand_fetch.sv
// Operand fetch: register-file read/write port driver with a busy scoreboard,
// writeback forwarding, hazard stall and a registered execute slot.
module jedro_1_operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  iss_valid_i,
    output logic                  iss_ready_o,
    input  logic [ADDR_WIDTH-1:0] iss_rs1_i,
    input  logic [ADDR_WIDTH-1:0] iss_rs2_i,
    input  logic [ADDR_WIDTH-1:0] iss_rd_i,
    input  logic                  iss_rd_we_i,

    output logic [ADDR_WIDTH-1:0] rpa_addr_o,
    input  logic [DATA_WIDTH-1:0] rpa_data_i,
    output logic [ADDR_WIDTH-1:0] rpb_addr_o,
    input  logic [DATA_WIDTH-1:0] rpb_data_i,

    output logic [ADDR_WIDTH-1:0] wpc_addr_o,
    output logic [DATA_WIDTH-1:0] wpc_data_o,
    output logic                  wpc_we_o,

    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,

    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [DATA_WIDTH-1:0] ex_op_a_o,
    output logic [DATA_WIDTH-1:0] ex_op_b_o,
    output logic [ADDR_WIDTH-1:0] ex_rd_o,
    output logic                  ex_rd_we_o,

    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic                  r_ex_valid;
    logic [DATA_WIDTH-1:0] r_ex_op_a;
    logic [DATA_WIDTH-1:0] r_ex_op_b;
    logic [ADDR_WIDTH-1:0] r_ex_rd;
    logic                  r_ex_rd_we;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    logic                  w_wb_hit_rs1;
    logic                  w_wb_hit_rs2;
    logic                  w_wb_hit_rd;
    logic                  w_blk_rs1;
    logic                  w_blk_rs2;
    logic                  w_blk_rd;
    logic                  w_hazard;
    logic                  w_slot_free;
    logic                  w_accept;
    logic                  w_stall;
    logic                  w_rd_set;
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;

    assign rpa_addr_o = iss_rs1_i;
    assign rpb_addr_o = iss_rs2_i;

    // Write port is a pure pass-through; x0 writes are suppressed here.
    assign wpc_addr_o = wb_rd_i;
    assign wpc_data_o = wb_data_i;
    assign wpc_we_o   = wb_valid_i & (wb_rd_i != '0);

    assign w_wb_hit_rs1 = wb_valid_i & (wb_rd_i == iss_rs1_i);
    assign w_wb_hit_rs2 = wb_valid_i & (wb_rd_i == iss_rs2_i);
    assign w_wb_hit_rd  = wb_valid_i & (wb_rd_i == iss_rd_i);

    // A pending register is released in the same cycle its writeback arrives.
    assign w_blk_rs1 = r_busy[iss_rs1_i] & ~w_wb_hit_rs1;
    assign w_blk_rs2 = r_busy[iss_rs2_i] & ~w_wb_hit_rs2;
    assign w_blk_rd  = r_busy[iss_rd_i] & ~w_wb_hit_rd;

    assign w_hazard = w_blk_rs1 | w_blk_rs2
                    | (iss_rd_we_i & (iss_rd_i != '0) & w_blk_rd);

    assign w_slot_free = ~r_ex_valid | ex_ready_i;
    assign iss_ready_o = w_slot_free & ~w_hazard & ~rst_i;
    assign w_accept    = iss_valid_i & iss_ready_o;
    assign w_stall     = iss_valid_i & w_slot_free & w_hazard;
    assign w_rd_set    = w_accept & iss_rd_we_i & (iss_rd_i != '0);

    always_comb begin
        w_op_a = rpa_data_i;
        if (iss_rs1_i == '0) begin
            w_op_a = '0;
        end else if (w_wb_hit_rs1) begin
            w_op_a = wb_data_i;
        end
    end

    always_comb begin
        w_op_b = rpb_data_i;
        if (iss_rs2_i == '0) begin
            w_op_b = '0;
        end else if (w_wb_hit_rs2) begin
            w_op_b = wb_data_i;
        end
    end

    // Clear first so that a same-index set in this cycle takes priority.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid_i) begin
            w_busy_nxt[wb_rd_i] = 1'b0;
        end
        if (w_rd_set) begin
            w_busy_nxt[iss_rd_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ex_valid <= 1'b0;
            r_ex_op_a  <= '0;
            r_ex_op_b  <= '0;
            r_ex_rd    <= '0;
            r_ex_rd_we <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_op_a  <= w_op_a;
            r_ex_op_b  <= w_op_b;
            r_ex_rd    <= iss_rd_i;
            r_ex_rd_we <= iss_rd_we_i;
        end else if (ex_ready_i) begin
            r_ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign ex_valid_o  = r_ex_valid;
    assign ex_op_a_o   = r_ex_op_a;
    assign ex_op_b_o   = r_ex_op_b;
    assign ex_rd_o     = r_ex_rd;
    assign ex_rd_we_o  = r_ex_rd_we;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_jedro_1_operand_fetch.sv
// Bench for jedro_1_operand_fetch: directed vectors, a register-file model,
// a pending-register model and per-cycle comparison of every output.
module tb_jedro_1_operand_fetch;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int NR = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          iss_valid_i = 1'b0;
    logic          iss_ready_o;
    logic [AW-1:0] iss_rs1_i = '0;
    logic [AW-1:0] iss_rs2_i = '0;
    logic [AW-1:0] iss_rd_i = '0;
    logic          iss_rd_we_i = 1'b0;
    logic [AW-1:0] rpa_addr_o;
    logic [DW-1:0] rpa_data_i;
    logic [AW-1:0] rpb_addr_o;
    logic [DW-1:0] rpb_data_i;
    logic [AW-1:0] wpc_addr_o;
    logic [DW-1:0] wpc_data_o;
    logic          wpc_we_o;
    logic          wb_valid_i = 1'b0;
    logic [AW-1:0] wb_rd_i = '0;
    logic [DW-1:0] wb_data_i = '0;
    logic          ex_valid_o;
    logic          ex_ready_i = 1'b1;
    logic [DW-1:0] ex_op_a_o;
    logic [DW-1:0] ex_op_b_o;
    logic [AW-1:0] ex_rd_o;
    logic          ex_rd_we_o;
    logic [CW-1:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    jedro_1_operand_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o),
        .iss_rs1_i(iss_rs1_i), .iss_rs2_i(iss_rs2_i),
        .iss_rd_i(iss_rd_i), .iss_rd_we_i(iss_rd_we_i),
        .rpa_addr_o(rpa_addr_o), .rpa_data_i(rpa_data_i),
        .rpb_addr_o(rpb_addr_o), .rpb_data_i(rpb_data_i),
        .wpc_addr_o(wpc_addr_o), .wpc_data_o(wpc_data_o),
        .wpc_we_o(wpc_we_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o),
        .ex_rd_o(ex_rd_o), .ex_rd_we_o(ex_rd_we_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file seen by the block (x0 deliberately holds garbage).
    logic [DW-1:0] rf [NR];
    assign rpa_data_i = rf[rpa_addr_o];
    assign rpb_data_i = rf[rpb_addr_o];
    always @(posedge clk_i) begin
        if (wpc_we_o) rf[wpc_addr_o] <= wpc_data_o;
    end

    // Model state: which registers await a result, and the execute slot.
    bit            m_pend [NR];
    bit            m_ex_v;
    logic [DW-1:0] m_a, m_b;
    logic [AW-1:0] m_rd;
    bit            m_we;
    int            m_cnt;

    function automatic bit wb_hits(logic [AW-1:0] r);
        return wb_valid_i && (wb_rd_i == r);
    endfunction

    function automatic bit waits_on(logic [AW-1:0] r);
        return m_pend[r] && !wb_hits(r);
    endfunction

    function automatic bit m_hazard();
        return waits_on(iss_rs1_i) || waits_on(iss_rs2_i) ||
               (iss_rd_we_i && iss_rd_i != 0 && waits_on(iss_rd_i));
    endfunction

    function automatic bit m_free();
        return !m_ex_v || ex_ready_i;
    endfunction

    function automatic bit m_ready();
        return m_free() && !m_hazard() && !rst_i;
    endfunction

    function automatic logic [DW-1:0] value_of(logic [AW-1:0] r);
        if (r == 0) return '0;
        if (wb_hits(r)) return wb_data_i;
        return rf[r];
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_ex_v = 0; m_a = '0; m_b = '0; m_rd = '0; m_we = 0;
            m_cnt = 0;
        end else begin
            bit take;
            bit stall;
            take  = iss_valid_i && m_ready();
            stall = iss_valid_i && m_free() && m_hazard();
            if (stall && m_cnt < (2 ** CW - 1)) m_cnt++;
            if (take) begin
                m_ex_v = 1;
                m_a = value_of(iss_rs1_i);
                m_b = value_of(iss_rs2_i);
                m_rd = iss_rd_i;
                m_we = iss_rd_we_i;
            end else if (ex_ready_i) begin
                m_ex_v = 0;
            end
            if (wb_valid_i) m_pend[wb_rd_i] = 0;
            if (take && iss_rd_we_i && iss_rd_i != 0) m_pend[iss_rd_i] = 1;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        chk("iss_ready", 64'(iss_ready_o), 64'(m_ready()));
        chk("rpa_addr", 64'(rpa_addr_o), 64'(iss_rs1_i));
        chk("rpb_addr", 64'(rpb_addr_o), 64'(iss_rs2_i));
        chk("wpc_we", 64'(wpc_we_o), 64'(wb_valid_i && wb_rd_i != 0));
        chk("wpc_addr", 64'(wpc_addr_o), 64'(wb_rd_i));
        chk("wpc_data", 64'(wpc_data_o), 64'(wb_data_i));
        chk("ex_valid", 64'(ex_valid_o), 64'(m_ex_v));
        chk("ex_op_a", 64'(ex_op_a_o), 64'(m_a));
        chk("ex_op_b", 64'(ex_op_b_o), 64'(m_b));
        chk("ex_rd", 64'(ex_rd_o), 64'(m_rd));
        chk("ex_rd_we", 64'(ex_rd_we_o), 64'(m_we));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
        #1;
    endtask

    task automatic issue(bit v, int rs1, int rs2, int rd, bit we);
        iss_valid_i = v;
        iss_rs1_i = AW'(rs1);
        iss_rs2_i = AW'(rs2);
        iss_rd_i = AW'(rd);
        iss_rd_we_i = we;
    endtask

    task automatic wb(bit v, int rd, logic [DW-1:0] d);
        wb_valid_i = v;
        wb_rd_i = AW'(rd);
        wb_data_i = d;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'hFFFF;
        rf[3] = 32'h11;
        rf[4] = 32'h22;

        // Reset state
        tick(); tick();
        at_neg();
        chk("rst_ex_valid", 64'(ex_valid_o), 64'd0);
        chk("rst_ready", 64'(iss_ready_o), 64'd0);
        chk("rst_cnt", 64'(stall_cnt_o), 64'd0);
        tick();
        rst_i = 1'b0;

        // 1: basic issue
        issue(1, 3, 4, 5, 1);
        at_neg();
        chk("t1_ready", 64'(iss_ready_o), 64'd1);
        tick();
        issue(0, 0, 0, 0, 0);
        at_neg();
        chk("t1_ex_valid", 64'(ex_valid_o), 64'd1);
        chk("t1_op_a", 64'(ex_op_a_o), 64'h11);
        chk("t1_op_b", 64'(ex_op_b_o), 64'h22);
        chk("t1_rd", 64'(ex_rd_o), 64'd5);
        tick();

        // 2: RAW stall on x5, released by same-cycle writeback
        issue(1, 5, 0, 6, 1);
        for (int i = 0; i < 3; i++) tick();
        at_neg();
        chk("t2_stalled", 64'(iss_ready_o), 64'd0);
        chk("t2_cnt", 64'(stall_cnt_o), 64'd3);
        tick();
        wb(1, 5, 32'hDEAD);
        at_neg();
        chk("t2_ready_wb", 64'(iss_ready_o), 64'd1);
        chk("t2_wpc_we", 64'(wpc_we_o), 64'd1);
        tick();
        wb(0, 0, '0);
        issue(0, 0, 0, 0, 0);
        at_neg();
        chk("t2_op_a", 64'(ex_op_a_o), 64'hDEAD);
        chk("t2_cnt_hold", 64'(stall_cnt_o), 64'd4);
        tick();

        // 3: x0 reads are zero, x0 writeback is suppressed
        issue(1, 0, 0, 0, 1);
        wb(1, 0, 32'h1234);
        at_neg();
        chk("t3_wpc_we", 64'(wpc_we_o), 64'd0);
        tick();
        wb(0, 0, '0);
        issue(1, 0, 0, 0, 0);
        at_neg();
        chk("t3_op_a", 64'(ex_op_a_o), 64'd0);
        chk("t3_op_b", 64'(ex_op_b_o), 64'd0);
        chk("t3_x0_free", 64'(iss_ready_o), 64'd1);
        tick();

        // 4: backpressure from execute, then zero-bubble load
        ex_ready_i = 1'b0;
        issue(1, 3, 4, 8, 0);
        tick(); tick();
        at_neg();
        chk("t4_ready", 64'(iss_ready_o), 64'd0);
        chk("t4_hold_v", 64'(ex_valid_o), 64'd1);
        chk("t4_hold_a", 64'(ex_op_a_o), 64'd0);
        chk("t4_cnt", 64'(stall_cnt_o), 64'd4);
        tick();
        ex_ready_i = 1'b1;
        at_neg();
        chk("t4_ready_now", 64'(iss_ready_o), 64'd1);
        tick();
        issue(0, 0, 0, 0, 0);
        at_neg();
        chk("t4_op_a", 64'(ex_op_a_o), 64'h11);
        chk("t4_rd", 64'(ex_rd_o), 64'd8);
        tick();

        // 5: set wins over clear on x7
        issue(1, 1, 2, 7, 1);
        tick();
        issue(1, 0, 0, 7, 1);
        wb(1, 7, 32'h77);
        at_neg();
        chk("t5_waw_ok", 64'(iss_ready_o), 64'd1);
        tick();
        wb(0, 0, '0);
        issue(1, 7, 0, 0, 0);
        at_neg();
        chk("t5_x7_busy", 64'(iss_ready_o), 64'd0);
        tick();

        // 6: async reset mid-stall, then saturation
        issue(1, 0, 0, 9, 1);
        tick();
        ex_ready_i = 1'b0;
        issue(1, 9, 0, 0, 0);
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_async_v", 64'(ex_valid_o), 64'd0);
        chk("t6_async_cnt", 64'(stall_cnt_o), 64'd0);
        chk("t6_async_a", 64'(ex_op_a_o), 64'd0);
        tick();
        rst_i = 1'b0;
        ex_ready_i = 1'b1;
        at_neg();
        chk("t6_x9_free", 64'(iss_ready_o), 64'd1);
        tick();
        issue(1, 0, 0, 10, 1);
        tick();
        issue(1, 10, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        at_neg();
        chk("t6_sat", 64'(stall_cnt_o), 64'd15);
        tick();
        issue(0, 0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
